// File: rtl/i2c_target_mem.sv
// I2C target with a small byte memory: acknowledges DEV_ADDR, sets a pointer from the
// first written byte, stores the bytes that follow and returns memory bytes on reads.
module i2c_target_mem #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int          DEPTH    = 16,
  localparam int         PW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i2c_scl_i,
  output logic          i2c_scl_o,
  output logic          i2c_scl_t,
  input  logic          i2c_sda_i,
  output logic          i2c_sda_o,
  output logic          i2c_sda_t,
  output logic          busy,
  input  logic [PW-1:0] dbg_adr_i,
  output logic [7:0]    dbg_dat_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_A_ACK,
    S_WR,
    S_W_ACK,
    S_RD,
    S_R_ACK
  } state_t;

  state_t        state;
  logic [2:0]    scl_q;
  logic [2:0]    sda_q;
  logic [7:0]    shreg;
  logic [3:0]    bit_cnt;
  logic          rw;
  logic          first;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_inc;
  logic          sda_t;
  logic [7:0]    mem [DEPTH];

  logic scl_s, scl_d, sda_s, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;

  // Two synchronizer stages, then one more stage so edges can be seen on bit [1] vs [2].
  // Reset to 1 (idle bus) so leaving reset never fakes a START or STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      // NOTE: clocked state is always written with <= so every register samples the
      // pre-edge value of its neighbours; blocking here would collapse the shift chain.
      scl_q <= {scl_q[1:0], i2c_scl_i};
      sda_q <= {sda_q[1:0], i2c_sda_i};
    end
  end

  assign scl_s     = scl_q[1];
  assign scl_d     = scl_q[2];
  assign sda_s     = sda_q[1];
  assign sda_d     = sda_q[2];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & ~sda_s & sda_d;
  assign stop_det  = scl_s & sda_s & ~sda_d;
  assign byte_in   = {shreg[6:0], sda_s};
  assign ptr_inc   = ptr + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      rw      <= 1'b0;
      first   <= 1'b0;
      ptr     <= '0;
      sda_t   <= 1'b1;
      busy    <= 1'b0;
      // NOTE: the memory is deliberately cleared on reset; it is only DEPTH bytes of
      // flops, and a known-zero image after reset is part of the block's contract.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (start_det) begin
      // Repeated START keeps ptr so a pointer write can be followed by a read.
      state   <= S_ADDR;
      bit_cnt <= '0;
      sda_t   <= 1'b1;
    end else if (stop_det) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      sda_t   <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (shreg[7:1] == DEV_ADDR) begin
              rw    <= shreg[0];
              if (!shreg[0]) first <= 1'b1;
              sda_t <= 1'b0;
              busy  <= 1'b1;
              state <= S_A_ACK;
            end else begin
              sda_t <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        S_A_ACK: begin
          if (scl_fall) begin
            bit_cnt <= '0;
            if (rw) begin
              shreg <= mem[ptr];
              sda_t <= mem[ptr][7];
              state <= S_RD;
            end else begin
              sda_t <= 1'b1;
              state <= S_WR;
            end
          end
        end
        S_WR: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (first) begin
                ptr   <= byte_in[PW-1:0];
                first <= 1'b0;
              end else begin
                mem[ptr] <= byte_in;
                ptr      <= ptr_inc;
              end
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_t <= 1'b0;
            state <= S_W_ACK;
          end
        end
        S_W_ACK: begin
          if (scl_fall) begin
            sda_t   <= 1'b1;
            bit_cnt <= '0;
            state   <= S_WR;
          end
        end
        S_RD: begin
          // bit_cnt == 8 marks a byte loaded after a master ACK whose MSB is not yet driven.
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_t   <= shreg[7];
              bit_cnt <= '0;
            end else if (bit_cnt == 4'd7) begin
              sda_t <= 1'b1;
              state <= S_R_ACK;
            end else begin
              shreg   <= {shreg[6:0], 1'b0};
              sda_t   <= shreg[6];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_R_ACK: begin
          if (scl_rise) begin
            ptr <= ptr_inc;
            if (!sda_s) begin
              shreg   <= mem[ptr_inc];
              bit_cnt <= 4'd8;
              state   <= S_RD;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign i2c_scl_o = 1'b0;
  assign i2c_scl_t = 1'b1;
  assign i2c_sda_o = 1'b0;
  assign i2c_sda_t = sda_t;
  assign dbg_dat_o = mem[dbg_adr_i];

endmodule

// File: tb/tb_i2c_target_mem.sv
// Directed and scoreboard-checked bench for i2c_target_mem, driving the open-drain bus
// with a bit-banged master.
module tb_i2c_target_mem;

  localparam int Q = 8;  // clk cycles per SCL phase

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  logic       i2c_scl_i, i2c_sda_i;
  logic       i2c_scl_o, i2c_scl_t, i2c_sda_o, i2c_sda_t;
  logic       busy;
  logic [3:0] dbg_adr_i;
  logic [7:0] dbg_dat_o;

  int         checks = 0;
  int         failures = 0;
  logic       busy_seen;
  logic [7:0] model [16];
  logic [3:0] model_ptr;

  always #5 clk = ~clk;

  assign i2c_scl_i = m_scl & (i2c_scl_t | i2c_scl_o);
  assign i2c_sda_i = m_sda & (i2c_sda_t | i2c_sda_o);

  i2c_target_mem #(.DEV_ADDR(7'h50), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .i2c_scl_i (i2c_scl_i),
    .i2c_scl_o (i2c_scl_o),
    .i2c_scl_t (i2c_scl_t),
    .i2c_sda_i (i2c_sda_i),
    .i2c_sda_o (i2c_sda_o),
    .i2c_sda_t (i2c_sda_t),
    .busy      (busy),
    .dbg_adr_i (dbg_adr_i),
    .dbg_dat_o (dbg_dat_o)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    dbg_adr_i = a;
    #1;
    d = dbg_dat_o;
  endtask

  task automatic start_c();
    wait_clk(3); m_sda = 1'b1;
    wait_clk(Q - 3); m_scl = 1'b1;
    wait_clk(Q); m_sda = 1'b0;
    wait_clk(Q); m_scl = 1'b0;
  endtask

  task automatic stop_c();
    wait_clk(3); m_sda = 1'b0;
    wait_clk(Q - 3); m_scl = 1'b1;
    wait_clk(Q); m_sda = 1'b1;
    wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    wait_clk(3); m_sda = b;
    wait_clk(Q - 3); m_scl = 1'b1;
    wait_clk(Q); m_scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_clk(3); m_sda = 1'b1;
    wait_clk(Q - 3); m_scl = 1'b1;
    wait_clk(Q / 2); b = i2c_sda_i;
    wait_clk(Q / 2); m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic nack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(nack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  // Pointer byte followed by n data bytes; the model tracks the expected memory image.
  task automatic tx_write(input logic [7:0] p, input logic [7:0] data [8], input int n);
    logic nack;
    start_c();
    write_byte(8'hA0, nack); check("wr_addr_ack", nack, 1'b0);
    write_byte(p, nack);     check("wr_ptr_ack", nack, 1'b0);
    model_ptr = p[3:0];
    for (int i = 0; i < n; i++) begin
      write_byte(data[i], nack);
      check("wr_data_ack", nack, 1'b0);
      model[model_ptr] = data[i];
      model_ptr = model_ptr + 4'd1;
    end
    stop_c();
  endtask

  // Pointer write, repeated START, n reads with the last one NACKed.
  task automatic tx_read(input logic [7:0] p, input int n, output logic [7:0] data [8]);
    logic       nack;
    logic [7:0] d;
    logic [7:0] dbg;
    start_c();
    write_byte(8'hA0, nack); check("rd_addr_w_ack", nack, 1'b0);
    write_byte(p, nack);     check("rd_ptr_ack", nack, 1'b0);
    start_c();
    write_byte(8'hA1, nack); check("rd_addr_r_ack", nack, 1'b0);
    check("rd_busy_high", busy, 1'b1);
    model_ptr = p[3:0];
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      data[i] = d;
      check("rd_data", d, model[model_ptr]);
      peek(model_ptr, dbg);
      check("rd_dbg", dbg, model[model_ptr]);
      model_ptr = model_ptr + 4'd1;
    end
    check("rd_busy_after_nack", busy, 1'b0);
    stop_c();
  endtask

  initial begin
    logic [7:0] buf_w [8];
    logic [7:0] buf_r [8];
    logic [7:0] d;
    logic       nack;
    logic [7:0] p;
    int         n;

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; dbg_adr_i = '0; busy_seen = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    model_ptr = '0;
    for (int i = 0; i < 8; i++) begin buf_w[i] = '0; buf_r[i] = '0; end
    wait_clk(4);
    rst = 1'b0;
    wait_clk(2);

    // Reset state
    check("rst_scl_o", i2c_scl_o, 1'b0);
    check("rst_scl_t", i2c_scl_t, 1'b1);
    check("rst_sda_o", i2c_sda_o, 1'b0);
    check("rst_sda_t", i2c_sda_t, 1'b1);
    check("rst_busy", busy, 1'b0);
    peek(4'd7, d); check("rst_dbg7", d, 8'h00);

    // Pointer write then data write
    buf_w[0] = 8'hA5; buf_w[1] = 8'h5A;
    tx_write(8'h03, buf_w, 2);
    peek(4'd3, d); check("pw_mem3", d, 8'hA5);
    peek(4'd4, d); check("pw_mem4", d, 8'h5A);
    check("pw_ptr", 32'(dut.ptr), 5);

    // Random read with repeated START
    tx_read(8'h03, 2, buf_r);
    check("rr_byte0", buf_r[0], 8'hA5);
    check("rr_byte1", buf_r[1], 8'h5A);
    check("rr_ptr", 32'(dut.ptr), 5);

    // Address mismatch
    busy_seen = 1'b0;
    start_c();
    write_byte(8'hA2, nack); check("mm_addr_nack", nack, 1'b1);
    write_byte(8'h00, nack); check("mm_data_nack", nack, 1'b1);
    stop_c();
    check("mm_busy_never", busy_seen, 1'b0);
    peek(4'd0, d); check("mm_mem0", d, 8'h00);
    peek(4'd3, d); check("mm_mem3", d, 8'hA5);
    check("mm_ptr", 32'(dut.ptr), 5);

    // Pointer wrap
    buf_w[0] = 8'h11; buf_w[1] = 8'h22; buf_w[2] = 8'h33;
    tx_write(8'h0F, buf_w, 3);
    peek(4'd15, d); check("wr_mem15", d, 8'h11);
    peek(4'd0, d);  check("wr_mem0", d, 8'h22);
    peek(4'd1, d);  check("wr_mem1", d, 8'h33);
    check("wr_ptr", 32'(dut.ptr), 2);

    // Reset mid-read: mem[0] = 0x22 has MSB 0, so the target drives SDA low on bit 7
    start_c();
    write_byte(8'hA0, nack); check("rm_addr_w_ack", nack, 1'b0);
    write_byte(8'h00, nack); check("rm_ptr_ack", nack, 1'b0);
    start_c();
    write_byte(8'hA1, nack); check("rm_addr_r_ack", nack, 1'b0);
    wait_clk(6);
    check("rm_driving_zero", i2c_sda_t, 1'b0);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("rm_sda_t", i2c_sda_t, 1'b1);
    check("rm_busy", busy, 1'b0);
    for (int i = 0; i < 16; i++) begin
      peek(4'(i), d);
      check("rm_mem_clear", d, 8'h00);
    end
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    model_ptr = '0;
    start_c();
    write_byte(8'hA1, nack); check("rm_after_ack", nack, 1'b0);
    read_byte(1'b1, d);      check("rm_after_byte", d, 8'h00);
    stop_c();

    // Random regression
    for (int t = 0; t < 40; t++) begin
      p = 8'($urandom_range(0, 255));
      n = int'($urandom_range(1, 8));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) buf_w[i] = 8'($urandom_range(0, 255));
        tx_write(p, buf_w, n);
      end else begin
        tx_read(p, n, buf_r);
      end
      check("rg_ptr", 32'(dut.ptr), 32'(model_ptr));
    end
    for (int i = 0; i < 16; i++) begin
      peek(4'(i), d);
      check("rg_final_mem", d, model[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
